// File: rtl/batch_scheduler.sv
// Batch sequencer: sample index, downsampled address, bank/cycle select,
// fill-then-run state machine. Optional batch_num under BATCH_SCHED_COUNT_EN.
module batch_scheduler #(
    parameter int depth = 32,
    parameter int OSR   = 1,
    localparam int BW   = $clog2(depth),
    localparam int NDS  = depth / OSR,
    localparam int DSW  = ($clog2(NDS) > 1) ? $clog2(NDS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [BW-1:0]  bat_count,
    output logic [BW-1:0]  bat_count_rev,
    output logic [DSW-1:0] ds_count,
    output logic [DSW-1:0] ds_count_rev,
    output logic           ds_tick,
    output logic [1:0]     cycle,
    output logic [3:0]     wr_bank,
    output logic           part_sel,
    output logic           batch_end,
    output logic           valid_out
`ifdef BATCH_SCHED_COUNT_EN
    ,
    output logic [15:0]    batch_num
`endif
);

    localparam int OW = ($clog2(OSR) > 1) ? $clog2(OSR) : 1;

    localparam logic [BW-1:0]  BAT_LAST = BW'(depth - 1);
    localparam logic [DSW-1:0] DS_LAST  = DSW'(NDS - 1);
    localparam logic [OW-1:0]  OSR_LAST = OW'(OSR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [BW-1:0]  r_bat;
    logic [DSW-1:0] r_ds;
    logic [OW-1:0]  r_osr;
    logic [1:0]     r_cycle;
    logic           r_fill;
    logic           r_valid;
    logic           w_batch_end;
    logic           w_ds_tick;
    logic           w_valid_nxt;

    assign w_batch_end = en && (r_bat == BAT_LAST);
    assign w_ds_tick   = en && (r_osr == OSR_LAST);

    // Sample, oversample and downsample counters; all clear together at
    // batch end so the last downsampled step is never repeated or lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bat   <= '0;
            r_ds    <= '0;
            r_osr   <= '0;
            r_cycle <= 2'd0;
        end else if (en) begin
            if (w_batch_end) begin
                r_bat   <= '0;
                r_ds    <= '0;
                r_osr   <= '0;
                r_cycle <= r_cycle + 2'd1;
            end else begin
                r_bat <= r_bat + BW'(1);
                if (w_ds_tick) begin
                    r_ds  <= r_ds + DSW'(1);
                    r_osr <= '0;
                end else begin
                    r_osr <= r_osr + OW'(1);
                end
            end
        end
    end

    // Remembers that the first fill batch has already ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= 1'b0;
        end else if (en && w_batch_end && (r_state == FILL)) begin
            r_fill <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: IDLE until first sample, FILL for two batches, then RUN.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                if (w_batch_end && r_fill) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_next_state = RUN;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output decode: a sample taken in RUN yields a valid result next cycle.
    always_comb begin
        w_valid_nxt = 1'b0;
        if (en && (r_state == RUN)) begin
            w_valid_nxt = 1'b1;
        end
    end

    // Registered result-valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

`ifdef BATCH_SCHED_COUNT_EN
    logic [15:0] r_batch_num;

    // Saturating count of completed batches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_batch_num <= 16'd0;
        end else if (w_batch_end && (r_batch_num != 16'hFFFF)) begin
            r_batch_num <= r_batch_num + 16'd1;
        end
    end

    assign batch_num = r_batch_num;
`endif

    assign bat_count     = r_bat;
    assign bat_count_rev = BAT_LAST - r_bat;
    assign ds_count      = r_ds;
    assign ds_count_rev  = DS_LAST - r_ds;
    assign ds_tick       = w_ds_tick;
    assign cycle         = r_cycle;
    assign wr_bank       = 4'b0001 << r_cycle;
    assign part_sel      = r_cycle[0];
    assign batch_end     = w_batch_end;
    assign valid_out     = r_valid;

endmodule

// File: tb/tb_batch_scheduler.sv
// Bench for batch_scheduler: OSR=1 and OSR=4 instances driven in lockstep,
// checked every cycle against an en-count model plus literal pins.
module tb_batch_scheduler;

    localparam int D = 32;

    logic       clk;
    logic       rst;
    logic       en;

    logic [4:0] bat1, batr1, ds1, dsr1;
    logic       tick1, be1, part1, vld1;
    logic [1:0] cyc1;
    logic [3:0] bank1;

    logic [4:0] bat4, batr4;
    logic [2:0] ds4, dsr4;
    logic       tick4, be4, part4, vld4;
    logic [1:0] cyc4;
    logic [3:0] bank4;

`ifdef BATCH_SCHED_COUNT_EN
    logic [15:0] bn1;
    logic [15:0] bn4;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state: en pulses since reset, expected valid_out.
    int n    = 0;
    bit vexp = 0;

    batch_scheduler #(.depth(D), .OSR(1)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bat_count     (bat1),
        .bat_count_rev (batr1),
        .ds_count      (ds1),
        .ds_count_rev  (dsr1),
        .ds_tick       (tick1),
        .cycle         (cyc1),
        .wr_bank       (bank1),
        .part_sel      (part1),
        .batch_end     (be1),
        .valid_out     (vld1)
`ifdef BATCH_SCHED_COUNT_EN
        ,
        .batch_num     (bn1)
`endif
    );

    batch_scheduler #(.depth(D), .OSR(4)) u_dut4 (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bat_count     (bat4),
        .bat_count_rev (batr4),
        .ds_count      (ds4),
        .ds_count_rev  (dsr4),
        .ds_tick       (tick4),
        .cycle         (cyc4),
        .wr_bank       (bank4),
        .part_sel      (part4),
        .batch_end     (be4),
        .valid_out     (vld4)
`ifdef BATCH_SCHED_COUNT_EN
        ,
        .batch_num     (bn4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: position derives from the number of accepted samples;
    // RUN once two whole batches (2*D samples) have been taken.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n    <= 0;
            vexp <= 1'b0;
        end else begin
            vexp <= en && (n >= 2 * D);
            n    <= n + (en ? 1 : 0);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int b;
        int c;
        b = n % D;
        c = (n / D) % 4;
        chk("bat1", int'(bat1), b);
        chk("batrev1", int'(batr1), D - 1 - b);
        chk("ds1", int'(ds1), b);
        chk("dsrev1", int'(dsr1), D - 1 - b);
        chk("tick1", int'(tick1), int'(en));
        chk("be1", int'(be1), (en && b == D - 1) ? 1 : 0);
        chk("cyc1", int'(cyc1), c);
        chk("bank1", int'(bank1), 1 << c);
        chk("part1", int'(part1), c % 2);
        chk("vld1", int'(vld1), vexp ? 1 : 0);
        chk("bat4", int'(bat4), b);
        chk("batrev4", int'(batr4), D - 1 - b);
        chk("ds4", int'(ds4), b / 4);
        chk("dsrev4", int'(dsr4), D / 4 - 1 - b / 4);
        chk("tick4", int'(tick4), (en && (n % 4) == 3) ? 1 : 0);
        chk("be4", int'(be4), (en && b == D - 1) ? 1 : 0);
        chk("cyc4", int'(cyc4), c);
        chk("bank4", int'(bank4), 1 << c);
        chk("part4", int'(part4), c % 2);
        chk("vld4", int'(vld4), vexp ? 1 : 0);
    end

    task automatic step(input logic e);
        @(posedge clk);
        #2;
        en = e;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_bat", int'(bat1), 0);
        chk("rst_batrev", int'(batr1), 31);
        chk("rst_dsrev4", int'(dsr4), 7);
        chk("rst_bank", int'(bank1), 1);
        chk("rst_vld", int'(vld1), 0);

        // Continuous en, 128 samples.
        for (int k = 0; k < 128; k++) begin
            step(1'b1);
            #1;
            if (k == 2) chk("p_tick4_k2", int'(tick4), 0);
            if (k == 3) chk("p_tick4_k3", int'(tick4), 1);
            if (k == 31) begin
                chk("p_be_31", int'(be1), 1);
                chk("p_cyc_31", int'(cyc1), 0);
                chk("p_ds4_31", int'(ds4), 7);
                chk("p_dsr4_31", int'(dsr4), 0);
            end
            if (k == 32) begin
                chk("p_cyc_32", int'(cyc1), 1);
                chk("p_ds4_32", int'(ds4), 0);
                chk("p_dsr4_32", int'(dsr4), 7);
            end
            if (k == 63) chk("p_be_63", int'(be1), 1);
            if (k == 64) chk("p_vld_64", int'(vld1), 0);
            if (k == 65) chk("p_vld_65", int'(vld1), 1);
            if (k == 95) chk("p_cyc_95", int'(cyc1), 2);
            if (k == 127) begin
                chk("p_be_127", int'(be1), 1);
                chk("p_cyc_127", int'(cyc1), 3);
            end
        end
        step(1'b0);
        #1;
        chk("p_cyc_wrap", int'(cyc1), 0);
        chk("p_bat_wrap", int'(bat1), 0);

        // en toggled 1,0: 70 accepted samples.
        for (int k = 0; k < 70; k++) begin
            step(1'b1);
            step(1'b0);
        end
        #1;
        chk("tog_bat", int'(bat1), 6);
        chk("tog_cyc", int'(cyc1), 2);
        chk("tog_bank", int'(bank1), 4);

        // Asynchronous reset mid-batch in RUN.
        for (int k = 0; k < 11; k++) step(1'b1);
        step(1'b0);
        #1;
        chk("pre_bat", int'(bat1), 17);
        chk("pre_cyc", int'(cyc1), 2);
        chk("pre_vld", int'(vld1), 1);
        rst = 1'b1;
        #1;
        chk("ar_bat", int'(bat1), 0);
        chk("ar_batrev", int'(batr1), 31);
        chk("ar_ds1", int'(ds1), 0);
        chk("ar_dsrev1", int'(dsr1), 31);
        chk("ar_dsrev4", int'(dsr4), 7);
        chk("ar_cyc", int'(cyc1), 0);
        chk("ar_bank", int'(bank1), 1);
        chk("ar_part", int'(part1), 0);
        chk("ar_vld", int'(vld1), 0);

        // rst wins over en.
        step(1'b1);
        step(1'b1);
        #1;
        chk("ov_bat", int'(bat1), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        en  = 1'b0;

        // Refill after reset: five batches.
        for (int k = 0; k < 160; k++) begin
            step(1'b1);
            #1;
            if (k == 40) chk("rf_vld_40", int'(vld4), 0);
            if (k == 64) chk("rf_vld_64", int'(vld1), 0);
            if (k == 65) chk("rf_vld_65", int'(vld1), 1);
        end
        step(1'b0);
        #1;
`ifdef BATCH_SCHED_COUNT_EN
        chk("bnum_5", int'(bn1), 5);
`endif

        // en gap at the last sample of a batch.
        for (int k = 0; k < 31; k++) step(1'b1);
        step(1'b0);
        #1;
        chk("gap_bat", int'(bat1), 31);
        chk("gap_be", int'(be1), 0);
        step(1'b0);
        step(1'b0);
        #1;
        chk("gap_be2", int'(be1), 0);
        chk("gap_cyc", int'(cyc1), 1);
        step(1'b1);
        #1;
        chk("gap_be3", int'(be1), 1);
        step(1'b0);
        #1;
        chk("gap_cyc2", int'(cyc1), 2);
        chk("gap_bat2", int'(bat1), 0);

`ifdef BATCH_SCHED_COUNT_EN
        force u_dut1.r_batch_num = 16'hFFFD;
        #1;
        release u_dut1.r_batch_num;
        for (int k = 0; k < 96; k++) begin
            step(1'b1);
            #1;
            if (k == 32) chk("bnum_fffe", int'(bn1), 16'hFFFE);
        end
        step(1'b0);
        #1;
        chk("bnum_sat", int'(bn1), 16'hFFFF);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/batch_scheduler.md
BATCH_SCHEDULER -- requirements
Module: batch_scheduler

Interface
REQ-001 SHALL have parameter depth, default 32, samples per batch; a multiple of OSR and at least 2*OSR.
REQ-002 SHALL have parameter OSR, default 1, oversampling ratio (input samples per downsampled step); at least 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1, input sample strobe; every sequential update is gated by en=1.
REQ-006 SHALL have port bat_count, output, $clog2(depth), forward sample index within the batch.
REQ-007 SHALL have port bat_count_rev, output, $clog2(depth), equal to depth-1-bat_count.
REQ-008 SHALL have port ds_count, output, max(1,$clog2(depth/OSR)), forward downsampled address.
REQ-009 SHALL have port ds_count_rev, output, same width as ds_count, equal to depth/OSR-1-ds_count.
REQ-010 SHALL have port ds_tick, output, 1, one-cycle strobe marking the last input sample of each downsampled step.
REQ-011 SHALL have port cycle, output, 2, batch cycle index, incremented mod 4 at each batch end.
REQ-012 SHALL have port wr_bank, output, 4, one-hot sample-bank write enable, equal to 1<<cycle.
REQ-013 SHALL have port part_sel, output, 1, equal to cycle[0]; selects the part-result RAM pair.
REQ-014 SHALL have port batch_end, output, 1, combinational; high while en=1 and bat_count=depth-1; drives the recursion reloads.
REQ-015 SHALL have port valid_out, output, 1, registered; high when the filter result for the current sample is valid.

Function
REQ-016 SHALL implement a state machine with states IDLE, FILL, RUN.
REQ-017 SHALL leave IDLE for FILL on the first en=1 cycle after reset.
REQ-018 SHALL stay in FILL until two complete batches have ended, then enter RUN; RUN is held until reset.
REQ-019 SHALL increment bat_count on each en=1 cycle and wrap it from depth-1 to 0 on the same edge that increments cycle.
REQ-020 SHALL keep an internal osr_count of 0..OSR-1 that advances on en=1 and wraps at OSR-1.
REQ-021 SHALL assert ds_tick when en=1 and osr_count=OSR-1; with OSR=1, ds_tick equals en.
REQ-022 SHALL increment ds_count on ds_tick and clear ds_count and osr_count at batch end, so the last step of a batch is never skipped or duplicated.
REQ-023 SHALL give cycle its wrap 3->0 with no extra latency.
REQ-024 SHALL set valid_out one cycle after any en=1 cycle seen in state RUN, and clear it otherwise.
REQ-025 SHALL hold all counters, cycle and state when en=0, with ds_tick and batch_end low.
REQ-026 SHALL treat an en gap at bat_count=depth-1 as no batch end until en returns.

Reset
REQ-027 SHALL on rst=1 set immediately: bat_count=0, bat_count_rev=depth-1, ds_count=0, ds_count_rev=depth/OSR-1, osr_count=0, cycle=0, wr_bank=4'b0001, part_sel=0, valid_out=0, state=IDLE.
REQ-028 SHALL let rst=1 override en=1 in the same cycle, and restart FILL from zero after reset mid-batch or in RUN.

Configuration
REQ-029 SHALL gate, under macro BATCH_SCHED_COUNT_EN, a 16-bit output batch_num, reset 0, incremented at each batch end and saturating at 16'hFFFF.
REQ-030 SHALL omit the batch_num port and its logic entirely when BATCH_SCHED_COUNT_EN is undefined; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover depth=32, OSR=1, en held 1 for 128 cycles -> batch_end on cycles 31, 63, 95, 127; cycle 0->1->2->3->0; valid_out first high on the cycle after the first en in batch 3 (cycle 64 after release).
REQ-032 SHALL cover depth=32, OSR=4, en held 1 -> ds_tick every 4th en; ds_count 0..7 then 0; ds_count_rev 7..0; no ds_count value repeated at a batch boundary.
REQ-033 SHALL cover en toggled 1,0 repeatedly -> counters advance only on en=1; batch_end and ds_tick never high while en=0.
REQ-034 SHALL cover rst pulsed asynchronously mid-batch in RUN (bat_count=17, cycle=2) -> outputs at reset values before the next clk edge; valid_out stays 0 for two batches afterwards.
REQ-035 SHALL cover BATCH_SCHED_COUNT_EN defined, 5 batches run -> batch_num=5; saturation at 16'hFFFF checked by forcing a value near the maximum.
